// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaler and period counter feeding NUM_CH compare
// channels, with edge/centre counting and shadowed settings applied at period boundaries.
module pwm_multi #(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned DIV_WIDTH = 16,
   parameter int unsigned PWM_BITS  = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [DIV_WIDTH-1:0]         div,
   input  logic [PWM_BITS-1:0]          top,
   input  logic                         center,
   input  logic [NUM_CH*PWM_BITS-1:0]   compare,
   input  logic [NUM_CH-1:0]            polarity,
   input  logic                         load,
   output logic [NUM_CH-1:0]            pwm_o,
   output logic                         period_o,
   output logic                         pending_o
);

   localparam int unsigned CMP_W = NUM_CH * PWM_BITS;

   typedef struct packed {
      logic [PWM_BITS-1:0] top;
      logic                center;
      logic [CMP_W-1:0]    compare;
      logic [NUM_CH-1:0]   polarity;
   } cfg_t;

   localparam cfg_t CFG_RST = '{top: '1, center: 1'b0, compare: '0, polarity: '0};

   logic [DIV_WIDTH-1:0] freq_count_q, freq_count_d;
   logic [PWM_BITS-1:0]  count_q, count_d;
   logic                 dir_q, dir_d;
   cfg_t                 staging_q, staging_d;
   cfg_t                 active_q, active_d;
   logic                 pending_q, pending_d;
   logic [NUM_CH-1:0]    pwm_q, pwm_d;
   logic                 period_q, period_d;

   cfg_t                 cfg_in;
   logic                 tick;
   logic                 boundary;

   // Prescaler tick and period-boundary detection (boundary = next count is 0)
   always_comb begin
      cfg_in   = '{top: top, center: center, compare: compare, polarity: polarity};
      tick     = enable && (freq_count_q == div);
      boundary = tick && ((active_q.top == '0) ||
                          (!active_q.center && (count_q == active_q.top)) ||
                          (active_q.center && dir_q && (count_q == PWM_BITS'(1))));
   end

   // Prescaler and period counter
   always_comb begin
      freq_count_d = freq_count_q;
      count_d      = count_q;
      dir_d        = dir_q;
      if (!enable) begin
         freq_count_d = '0;
         count_d      = '0;
         dir_d        = 1'b0;
      end else if (tick) begin
         freq_count_d = '0;
         if (boundary) begin
            count_d = '0;
            dir_d   = 1'b0;
         end else if (!active_q.center) begin
            count_d = count_q + PWM_BITS'(1);
         end else if (!dir_q) begin
            count_d = count_q + PWM_BITS'(1);
            dir_d   = ((count_q + PWM_BITS'(1)) == active_q.top);
         end else begin
            count_d = count_q - PWM_BITS'(1);
         end
      end else begin
         freq_count_d = freq_count_q + DIV_WIDTH'(1);
      end
   end

   // Shadow registers: staged values move to active at a boundary or while idle
   always_comb begin
      staging_d = staging_q;
      active_d  = active_q;
      pending_d = pending_q;
      if (load && boundary) begin
         staging_d = cfg_in;
         active_d  = cfg_in;
         pending_d = 1'b0;
      end else if (load) begin
         if (!enable && pending_q) begin
            active_d = staging_q;
         end
         staging_d = cfg_in;
         pending_d = 1'b1;
      end else if ((boundary || !enable) && pending_q) begin
         active_d  = staging_q;
         pending_d = 1'b0;
      end
   end

   // Channel compare and period pulse
   always_comb begin
      period_d = boundary;
      pwm_d    = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         pwm_d[i] = active_q.polarity[i] ^
                    (enable && (count_q < active_q.compare[i*PWM_BITS +: PWM_BITS]));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         freq_count_q <= '0;
         count_q      <= '0;
         dir_q        <= 1'b0;
         staging_q    <= CFG_RST;
         active_q     <= CFG_RST;
         pending_q    <= 1'b0;
         pwm_q        <= '0;
         period_q     <= 1'b0;
      end else begin
         freq_count_q <= freq_count_d;
         count_q      <= count_d;
         dir_q        <= dir_d;
         staging_q    <= staging_d;
         active_q     <= active_d;
         pending_q    <= pending_d;
         pwm_q        <= pwm_d;
         period_q     <= period_d;
      end
   end

   assign pwm_o     = pwm_q;
   assign period_o  = period_q;
   assign pending_o = pending_q;

endmodule
